hall_call_dispatcher: RTL and testbench

Upstream feeder for the lift controller. Latches hall-call buttons (up/down per landing), drives the call lamps, and serializes pending calls onto the controller's 4-bit floor-request input as single-cycle floor codes separated by idle code 4'hF. Watches controller floor/motor outputs to cancel served calls, and re-issues calls left unserved after a timeout.

---
 rtl/lift_pkg.sv | 19 +
 rtl/rr_floor_picker.sv | 27 ++
 rtl/hall_call_dispatcher.sv | 131 +++++++++++++
 tb/tb_hall_call_dispatcher.sv | 246 ++++++++++++++++++++++++
 4 files changed

// File: rtl/lift_pkg.sv
// Constants and types shared by the lift controller and its hall-call dispatcher.
package lift_pkg;
   localparam int NUM_FLOORS = 11;
   localparam logic [3:0] FLOOR_NONE = 4'hF;

   localparam logic [1:0] MOTOR_IDLE = 2'b00;
   localparam logic [1:0] MOTOR_UP   = 2'b11;
   localparam logic [1:0] MOTOR_DN   = 2'b10;

   // The top landing has no up button and the ground landing has no down button.
   localparam logic [NUM_FLOORS-1:0] UP_MASK = 11'h3FF;
   localparam logic [NUM_FLOORS-1:0] DN_MASK = 11'h7FE;

   typedef enum logic [1:0] {IDLE, ISSUE, GAP} disp_state_e;

   function automatic logic [3:0] next_floor(input logic [3:0] f);
      return (f == 4'(NUM_FLOORS-1)) ? 4'd0 : f + 4'd1;
   endfunction
endpackage

// File: rtl/rr_floor_picker.sv
// Round-robin pick of the first candidate floor at or after ptr_i, wrapping 10 -> 0.
// Purely combinational.
module rr_floor_picker
   import lift_pkg::*;
(
   input  logic [NUM_FLOORS-1:0] cand_i,
   input  logic [3:0]            ptr_i,
   output logic                  found_o,
   output logic [3:0]            floor_o
);
   logic [3:0] idx;
   logic       hit;

   always_comb begin
      hit     = 1'b0;
      floor_o = FLOOR_NONE;
      idx     = ptr_i;
      for (int i = 0; i < NUM_FLOORS; i++) begin
         if (!hit && (idx < 4'(NUM_FLOORS)) && cand_i[idx]) begin
            hit     = 1'b1;
            floor_o = idx;
         end
         idx = next_floor(idx);
      end
      found_o = hit;
   end
endmodule

// File: rtl/hall_call_dispatcher.sv
// Latches hall calls, drives lamps, and serializes pending calls as one-cycle floor codes.
// Code appears two edges after a press; no backpressure, the controller must sample every code.
module hall_call_dispatcher
   import lift_pkg::*;
#(
   parameter int GAP_CYCLES   = 1,
   parameter int RETRY_CYCLES = 64
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [NUM_FLOORS-1:0] hall_up,
   input  logic [NUM_FLOORS-1:0] hall_dn,
   input  logic [3:0]            lift_floor,
   input  logic [1:0]            lift_motor,
   output logic [3:0]            floor_req,
   output logic [NUM_FLOORS-1:0] up_lamp,
   output logic [NUM_FLOORS-1:0] dn_lamp,
   output logic                  busy
);
   localparam int RW = $clog2(RETRY_CYCLES);
   localparam int GW = $clog2(GAP_CYCLES + 1);
   localparam logic [RW-1:0] RETRY_LAST = RW'(RETRY_CYCLES - 1);
   localparam logic [GW-1:0] GAP_LOAD   = GW'(GAP_CYCLES - 1);

   disp_state_e           state_q, state_d;
   logic [3:0]            floor_req_q, floor_req_d;
   logic [NUM_FLOORS-1:0] up_lamp_q, up_lamp_d;
   logic [NUM_FLOORS-1:0] dn_lamp_q, dn_lamp_d;
   logic [NUM_FLOORS-1:0] disp_q, disp_d;
   logic [3:0]            ptr_q, ptr_d;
   logic [RW-1:0]         retry_cnt_q, retry_cnt_d;
   logic [GW-1:0]         gap_cnt_q, gap_cnt_d;

   logic [NUM_FLOORS-1:0] arrive;
   logic [NUM_FLOORS-1:0] cand;
   logic                  pick_found;
   logic [3:0]            pick_floor;

   always_comb begin
      arrive = '0;
      for (int f = 0; f < NUM_FLOORS; f++) begin
         arrive[f] = (lift_motor == MOTOR_IDLE) && (lift_floor == 4'(f));
      end
   end

   // Excluding arriving floors keeps a pick from colliding with that floor's clear.
   assign cand = (up_lamp_q | dn_lamp_q) & ~disp_q & ~arrive;
   assign busy = (|up_lamp_q) | (|dn_lamp_q);

   rr_floor_picker u_picker (
      .cand_i  (cand),
      .ptr_i   (ptr_q),
      .found_o (pick_found),
      .floor_o (pick_floor)
   );

   always_comb begin
      state_d     = state_q;
      floor_req_d = floor_req_q;
      up_lamp_d   = (up_lamp_q | (hall_up & UP_MASK)) & ~arrive;
      dn_lamp_d   = (dn_lamp_q | (hall_dn & DN_MASK)) & ~arrive;
      disp_d      = disp_q & ~arrive;
      ptr_d       = ptr_q;
      retry_cnt_d = '0;
      gap_cnt_d   = gap_cnt_q;

      case (state_q)
         IDLE: begin
            if (pick_found) begin
               floor_req_d        = pick_floor;
               disp_d[pick_floor] = 1'b1;
               ptr_d              = next_floor(pick_floor);
               state_d            = ISSUE;
            end else begin
               floor_req_d = FLOOR_NONE;
               // Lamps still lit with nothing left to issue: calls went unserved.
               if (busy) begin
                  if (retry_cnt_q == RETRY_LAST) begin
                     disp_d = '0;
                  end else begin
                     retry_cnt_d = retry_cnt_q + RW'(1);
                  end
               end
            end
         end
         ISSUE: begin
            floor_req_d = FLOOR_NONE;
            gap_cnt_d   = GAP_LOAD;
            state_d     = GAP;
         end
         GAP: begin
            floor_req_d = FLOOR_NONE;
            if (gap_cnt_q == '0) begin
               state_d = IDLE;
            end else begin
               gap_cnt_d = gap_cnt_q - GW'(1);
            end
         end
         default: begin
            floor_req_d = FLOOR_NONE;
            state_d     = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= IDLE;
         floor_req_q <= FLOOR_NONE;
         up_lamp_q   <= '0;
         dn_lamp_q   <= '0;
         disp_q      <= '0;
         ptr_q       <= '0;
         retry_cnt_q <= '0;
         gap_cnt_q   <= '0;
      end else begin
         state_q     <= state_d;
         floor_req_q <= floor_req_d;
         up_lamp_q   <= up_lamp_d;
         dn_lamp_q   <= dn_lamp_d;
         disp_q      <= disp_d;
         ptr_q       <= ptr_d;
         retry_cnt_q <= retry_cnt_d;
         gap_cnt_q   <= gap_cnt_d;
      end
   end

   assign floor_req = floor_req_q;
   assign up_lamp   = up_lamp_q;
   assign dn_lamp   = dn_lamp_q;
endmodule

// File: tb/tb_hall_call_dispatcher.sv
// Randomized and directed bench for hall_call_dispatcher against a cycle-level call model.
module tb_hall_call_dispatcher;
   localparam int NF    = 11;
   localparam int GAP   = 1;
   localparam int RETRY = 64;
   localparam logic [3:0] NONE = 4'hF;

   logic          clk = 1'b0;
   logic          rst;
   logic [NF-1:0] hall_up, hall_dn;
   logic [3:0]    lift_floor;
   logic [1:0]    lift_motor;
   logic [3:0]    floor_req;
   logic [NF-1:0] up_lamp, dn_lamp;
   logic          busy;

   int n_chk  = 0;
   int n_fail = 0;

   hall_call_dispatcher #(.GAP_CYCLES(GAP), .RETRY_CYCLES(RETRY)) dut (
      .clk        (clk),
      .rst        (rst),
      .hall_up    (hall_up),
      .hall_dn    (hall_dn),
      .lift_floor (lift_floor),
      .lift_motor (lift_motor),
      .floor_req  (floor_req),
      .up_lamp    (up_lamp),
      .dn_lamp    (dn_lamp),
      .busy       (busy)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
      end
   endtask

   // Model: lit calls, dispatched flags, a rotating start floor, a cooldown after each
   // issued code, and a count of consecutive fruitless scans with lamps lit.
   bit         m_up[NF], m_dn[NF], m_disp[NF];
   int         m_ptr, m_cool, m_scan;
   logic [3:0] m_req;

   function automatic void model_reset();
      for (int f = 0; f < NF; f++) begin
         m_up[f] = 0; m_dn[f] = 0; m_disp[f] = 0;
      end
      m_ptr = 0; m_cool = 0; m_scan = 0; m_req = NONE;
   endfunction

   function automatic logic [NF-1:0] pack(input bit a[NF]);
      logic [NF-1:0] v;
      for (int f = 0; f < NF; f++) v[f] = a[f];
      return v;
   endfunction

   task automatic model_edge();
      bit arr[NF];
      bit cand[NF];
      bit any_lamp;
      int pick;
      any_lamp = 0;
      for (int f = 0; f < NF; f++) begin
         arr[f]   = (lift_motor == 2'b00) && (int'(lift_floor) == f);
         any_lamp = any_lamp | m_up[f] | m_dn[f];
         cand[f]  = (m_up[f] || m_dn[f]) && !m_disp[f] && !arr[f];
      end
      pick = -1;
      if (m_cool == 0) begin
         for (int k = 0; k < NF; k++) begin
            int f;
            f = (m_ptr + k) % NF;
            if (pick < 0 && cand[f]) pick = f;
         end
      end
      for (int f = 0; f < NF; f++) begin
         m_up[f] = (m_up[f] || (hall_up[f] && f != NF-1)) && !arr[f];
         m_dn[f] = (m_dn[f] || (hall_dn[f] && f != 0)) && !arr[f];
         if (arr[f]) m_disp[f] = 0;
      end
      if (pick >= 0) begin
         m_req        = 4'(pick);
         m_disp[pick] = 1;
         m_ptr        = (pick + 1) % NF;
         m_cool       = 1 + GAP;
         m_scan       = 0;
      end else begin
         m_req = NONE;
         if (m_cool > 0) begin
            m_cool--;
            m_scan = 0;
         end else if (any_lamp) begin
            m_scan++;
            if (m_scan == RETRY) begin
               for (int f = 0; f < NF; f++) m_disp[f] = 0;
               m_scan = 0;
            end
         end else begin
            m_scan = 0;
         end
      end
   endtask

   task automatic step();
      model_edge();
      @(posedge clk);
      #1;
      chk("floor_req", floor_req, m_req);
      chk("up_lamp", up_lamp, pack(m_up));
      chk("dn_lamp", dn_lamp, pack(m_dn));
      chk("busy", busy, (|pack(m_up)) | (|pack(m_dn)));
   endtask

   task automatic run(input int n);
      repeat (n) step();
   endtask

   task automatic press(input logic [NF-1:0] up, input logic [NF-1:0] dn);
      hall_up = up;
      hall_dn = dn;
      step();
      hall_up = '0;
      hall_dn = '0;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      #2;
      model_reset();
      rst = 1'b0;
   endtask

   initial begin
      int seen[$];
      logic [3:0] prev;

      hall_up = '0; hall_dn = '0;
      lift_floor = 4'd0; lift_motor = 2'b11;
      rst = 1'b1;
      #1;
      chk("rst_req", floor_req, NONE);
      chk("rst_up", up_lamp, 0);
      chk("rst_dn", dn_lamp, 0);
      chk("rst_busy", busy, 0);
      #12;
      model_reset();
      rst = 1'b0;

      // Single call: lamp after the sampling edge, code one edge later for one cycle.
      press(11'b1 << 4, '0);
      chk("single_lamp", up_lamp[4], 1);
      step();
      chk("single_req", floor_req, 4);
      step();
      chk("single_req_end", floor_req, NONE);
      run(3);

      // Round robin from ptr 0.
      do_reset();
      press((11'b1 << 2) | (11'b1 << 9), 11'b1 << 7);
      prev = floor_req;
      for (int i = 0; i < 14; i++) begin
         step();
         if (floor_req != NONE) begin
            seen.push_back(int'(floor_req));
            chk("rr_one_cycle", prev, NONE);
         end
         prev = floor_req;
      end
      chk("rr_count", seen.size(), 3);
      if (seen.size() == 3) begin
         chk("rr_0", seen[0], 2);
         chk("rr_1", seen[1], 7);
         chk("rr_2", seen[2], 9);
      end

      // Arrival clears both lamps even with a simultaneous press.
      do_reset();
      press(11'b1 << 5, 11'b1 << 5);
      run(6);
      lift_floor = 4'd5; lift_motor = 2'b00; hall_up = 11'b1 << 5;
      step();
      chk("arr_up5", up_lamp[5], 0);
      chk("arr_dn5", dn_lamp[5], 0);
      hall_up = '0; lift_floor = 4'd0; lift_motor = 2'b11;
      run(3);

      // Retry: unserved call re-issued once per retry window.
      do_reset();
      press(11'b1 << 6, '0);
      seen.delete();
      for (int i = 0; i < 200; i++) begin
         step();
         if (floor_req == 4'd6) seen.push_back(i);
      end
      chk("retry_issues", seen.size(), 3);
      if (seen.size() >= 2) chk("retry_interval", seen[1] - seen[0], RETRY + GAP + 2);

      // Missing buttons and out-of-range floor.
      do_reset();
      hall_up = 11'b1 << 10; hall_dn = 11'b1;
      run(4);
      hall_up = '0; hall_dn = '0;
      chk("bound_lamps", up_lamp | dn_lamp, 0);
      chk("bound_busy", busy, 0);
      press(11'b1 << 3, '0);
      lift_floor = 4'd12; lift_motor = 2'b00;
      run(3);
      chk("nofloor_lamp", up_lamp[3], 1);
      lift_floor = 4'd0; lift_motor = 2'b11;
      run(4);

      // Random traffic.
      for (int i = 0; i < 400; i++) begin
         hall_up = ($urandom_range(0, 5) == 0) ? 11'($urandom) : 11'd0;
         hall_dn = ($urandom_range(0, 5) == 0) ? 11'($urandom) : 11'd0;
         if (i % 4 == 0) begin
            lift_floor = 4'($urandom_range(0, 15));
            lift_motor = 2'($urandom);
         end
         step();
      end
      hall_up = '0; hall_dn = '0;

      // Asynchronous reset while a code is on the output.
      do_reset();
      lift_floor = 4'd0; lift_motor = 2'b11;
      press(11'b1 << 3, '0);
      step();
      chk("pre_rst_req", floor_req, 3);
      #2;
      rst = 1'b1;
      #1;
      chk("arst_req", floor_req, NONE);
      chk("arst_lamps", up_lamp | dn_lamp, 0);
      chk("arst_busy", busy, 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
